// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit that owns the HI/LO registers.
// Each operation takes 32 cycles: shift-add multiply or restoring divide on operand magnitudes, with signs restored at the end.
module mult_div_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] operand_a,
   input  logic [DATA_W-1:0] operand_b,
   input  logic              hi_wr,
   input  logic              lo_wr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic              div_by_zero,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   count;

   logic               op_div;
   logic               zero_div;
   logic               neg_q;
   logic               neg_r;
   logic [DATA_W-1:0]  mag_a;
   logic [DATA_W-1:0]  mag_b;
   logic [2*DATA_W-1:0] acc;

   logic [DATA_W:0]     mul_sum;
   logic [DATA_W:0]     div_shift;
   logic [DATA_W:0]     div_trial;
   logic [2*DATA_W-1:0] mul_next;
   logic [2*DATA_W-1:0] div_next;
   logic [2*DATA_W-1:0] acc_next;
   logic [2*DATA_W-1:0] product;
   logic [DATA_W-1:0]   quot;
   logic [DATA_W-1:0]   rem;
   logic [DATA_W-1:0]   hi_res;
   logic [DATA_W-1:0]   lo_res;

   function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                   input logic is_signed);
      // The most negative value maps onto its own unsigned magnitude.
      return (is_signed && v[DATA_W-1]) ? DATA_W'(-v) : DATA_W'(v);
   endfunction

   function automatic logic [DATA_W-1:0] apply_sign_w(input logic [DATA_W-1:0] v, input logic neg);
      return neg ? DATA_W'(-v) : v;
   endfunction

   function automatic logic [2*DATA_W-1:0] apply_sign_2w(input logic [2*DATA_W-1:0] v, input logic neg);
      return neg ? (2*DATA_W)'(-v) : v;
   endfunction

   always_comb begin
      // Multiply: acc = {partial product, remaining multiplier bits}.
      mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mag_a} : '0);
      mul_next  = {mul_sum, acc[DATA_W-1:1]};
      // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
      div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
      div_trial = div_shift - {1'b0, mag_b};
      div_next  = div_trial[DATA_W] ? {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                    : {div_trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      acc_next  = op_div ? div_next : mul_next;

      product = apply_sign_2w(acc_next, neg_q);
      quot    = apply_sign_w(acc_next[DATA_W-1:0], neg_q);
      rem     = apply_sign_w(acc_next[2*DATA_W-1:DATA_W], neg_r);
      hi_res  = op_div ? rem : product[2*DATA_W-1:DATA_W];
      lo_res  = op_div ? (zero_div ? '1 : quot) : product[DATA_W-1:0];
   end

   // Operand capture at the accepting edge, then one iteration per RUN cycle.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         op_div   <= op[1];
         zero_div <= op[1] && (operand_b == '0);
         neg_q    <= !op[0] && (operand_a[DATA_W-1] ^ operand_b[DATA_W-1]);
         neg_r    <= !op[0] && operand_a[DATA_W-1];
         mag_a    <= magnitude($signed(operand_a), !op[0]);
         mag_b    <= magnitude($signed(operand_b), !op[0]);
         acc      <= {{DATA_W{1'b0}}, op[1] ? magnitude($signed(operand_a), !op[0])
                                            : magnitude($signed(operand_b), !op[0])};
      end else if (state == RUN) begin
         acc <= acc_next;
      end
   end

   // Sequencing and the architecturally visible HI/LO registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         count       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  count <= '0;
               end else begin
                  if (hi_wr) hi <= wr_data;
                  if (lo_wr) lo <= wr_data;
               end
            end
            RUN: begin
               count <= count + 1'b1;
               if (count == LAST) begin
                  state       <= DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  div_by_zero <= zero_div;
                  hi          <= hi_res;
                  lo          <= lo_res;
               end
            end
            DONE: begin
               state       <= IDLE;
               done        <= 1'b0;
               div_by_zero <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed operations checked against a cycle-level arithmetic model every cycle,
// plus literal expectations at each completion.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        hi_wr = 1'b0;
   logic        lo_wr = 1'b0;
   logic [31:0] wr_data = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_fail = 0;

   mult_div_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b),
      .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
      .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Architectural result as {HI, LO}.
   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p, q, rr;
      longint unsigned ua, ub;
      logic [63:0] r, qv, rv;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      r = '0;
      if (o[1] && b == 32'd0) begin
         r = {a, 32'hFFFF_FFFF};
      end else begin
         case (o)
            2'b00: begin p = sa * sb; r = p; end
            2'b01: r = ua * ub;
            2'b10: begin q = sa / sb; rr = sa % sb; qv = q; rv = rr; r = {rv[31:0], qv[31:0]}; end
            default: begin qv = ua / ub; rv = ua % ub; r = {rv[31:0], qv[31:0]}; end
         endcase
      end
      return r;
   endfunction

   // Cycle-level model: an accepted start produces its result 32 edges later, then one done cycle.
   logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0, m_pend_dbz = 1'b0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [63:0] m_pend = '0;
   int          m_left = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
         m_hi <= '0; m_lo <= '0; m_left <= 0;
      end else if (m_left != 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_dbz  <= m_pend_dbz;
            m_hi   <= m_pend[63:32];
            m_lo   <= m_pend[31:0];
         end
      end else if (m_done) begin
         m_done <= 1'b0;
         m_dbz  <= 1'b0;
      end else if (start) begin
         m_left     <= 32;
         m_busy     <= 1'b1;
         m_pend     <= ref_result(op, operand_a, operand_b);
         m_pend_dbz <= op[1] && (operand_b == 32'd0);
      end else begin
         if (hi_wr) m_hi <= wr_data;
         if (lo_wr) m_lo <= wr_data;
      end
   end

   always @(negedge clk) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
   end

   task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                         input bit now, input bit wr_at_start, input int inject);
      int nbusy;
      bit seen;
      if (!now) @(negedge clk);
      op = o; operand_a = a; operand_b = b; start = 1'b1;
      if (wr_at_start) begin hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'hDEAD_BEEF; end
      @(negedge clk);
      start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
      operand_a = $urandom; operand_b = $urandom; op = 2'($urandom);
      nbusy = 0;
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (done) begin seen = 1'b1; break; end
         if (busy) nbusy++;
         start = (k == inject); hi_wr = (k == inject); wr_data = 32'h0000_1234;
         @(negedge clk);
      end
      start = 1'b0; hi_wr = 1'b0;
      chk({nm, "_done_seen"}, 64'(seen), 64'd1);
      chk({nm, "_busy_cycles"}, 64'(nbusy), 64'd32);
      chk({nm, "_hi"}, 64'(hi), 64'(ehi));
      chk({nm, "_lo"}, 64'(lo), 64'(elo));
      chk({nm, "_dbz"}, 64'(div_by_zero), 64'(edbz));
      @(negedge clk);
      chk({nm, "_done_clear"}, 64'(done), 64'd0);
      chk({nm, "_dbz_clear"}, 64'(div_by_zero), 64'd0);
   endtask

   initial begin
      chk("pin_multu", ref_result(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
      chk("pin_mult", ref_result(2'b00, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
      chk("pin_div", ref_result(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
      chk("pin_div_ovf", ref_result(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

      repeat (2) @(negedge clk);
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      reset = 1'b1;
      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1, 1'b0, -1);
      run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0, 1'b0, -1);
      run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, -1);
      run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, -1);
      run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, -1);
      run_op("div_zero_neg", 2'b10, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, -1);
      run_op("run_inject", 2'b01, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 9);

      // HI/LO writes while idle.
      hi_wr = 1'b1; wr_data = 32'h0000_1234;
      @(negedge clk);
      hi_wr = 1'b0;
      chk("idle_mthi_hi", 64'(hi), 64'h0000_1234);
      chk("idle_mthi_lo", 64'(lo), 64'h0000_000C);
      hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'hA5A5_0F0F;
      @(negedge clk);
      hi_wr = 1'b0; lo_wr = 1'b0;
      chk("idle_both_hi", 64'(hi), 64'hA5A5_0F0F);
      chk("idle_both_lo", 64'(lo), 64'hA5A5_0F0F);

      run_op("start_wins", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0, 1'b1, 1'b1, -1);
      run_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'd10, 32'h0000_0005, 32'h1999_9999, 1'b0, 1'b0, 1'b0, -1);
      run_op("div_negb", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, -1);

      // Abort an operation with reset in the middle of RUN.
      @(negedge clk);
      op = 2'b01; operand_a = 32'h0000_1000; operand_b = 32'h0000_2000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      chk("pre_abort_busy", 64'(busy), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) chk("abort_no_done", 64'(done), 64'd0);
      end
      chk("abort_idle_lo", 64'(lo), 64'd0);
      run_op("multu_6x7", 2'b01, 32'd6, 32'd7, 32'h0000_0000, 32'd42, 1'b0, 1'b0, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
